scalar_rs: RTL

Reservation station for the scalar integer pipeline. It accepts decoded ALU/branch micro-ops from the dispatcher and holds them until both source operands are available. Operands are captured from the ALU and load/store result broadcasts. Each cycle it issues at most one ready micro-op to `scalar_alu` using that unit's `valid/work_type/r1/r2/inst_rob_id` input contract.

---
 rtl/scalar_rs.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/scalar_rs.sv
// Reservation station for the scalar integer pipeline: holds dispatched micro-ops
// until both operands arrive from result broadcasts, then issues one per cycle.
module scalar_rs #(
  parameter int RS_SIZE_BIT   = 3,
  parameter int RS_TYPE_BIT   = 4,
  parameter int ROB_WIDTH_BIT = 4
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic                     clear,
  input  logic                     inst_valid,
  input  logic [RS_TYPE_BIT-1:0]   inst_type,
  input  logic [ROB_WIDTH_BIT-1:0] inst_rob_id,
  input  logic [31:0]              inst_r1,
  input  logic [31:0]              inst_r2,
  input  logic                     inst_has_dep1,
  input  logic                     inst_has_dep2,
  input  logic [ROB_WIDTH_BIT-1:0] inst_dep1,
  input  logic [ROB_WIDTH_BIT-1:0] inst_dep2,
  output logic                     full,
  input  logic                     alu_ready,
  input  logic [ROB_WIDTH_BIT-1:0] alu_rob_id,
  input  logic [31:0]              alu_value,
  input  logic                     lsb_ready,
  input  logic [ROB_WIDTH_BIT-1:0] lsb_rob_id,
  input  logic [31:0]              lsb_value,
  output logic                     exec_valid,
  output logic [RS_TYPE_BIT-1:0]   exec_type,
  output logic [31:0]              exec_r1,
  output logic [31:0]              exec_r2,
  output logic [ROB_WIDTH_BIT-1:0] exec_rob_id
);
  localparam int N = 1 << RS_SIZE_BIT;

  logic [N-1:0]             busy_q, busy_d, hq1_q, hq1_d, hq2_q, hq2_d;
  logic [RS_TYPE_BIT-1:0]   type_q [N];
  logic [RS_TYPE_BIT-1:0]   type_d [N];
  logic [ROB_WIDTH_BIT-1:0] rob_q  [N];
  logic [ROB_WIDTH_BIT-1:0] rob_d  [N];
  logic [ROB_WIDTH_BIT-1:0] q1_q   [N];
  logic [ROB_WIDTH_BIT-1:0] q1_d   [N];
  logic [ROB_WIDTH_BIT-1:0] q2_q   [N];
  logic [ROB_WIDTH_BIT-1:0] q2_d   [N];
  logic [31:0]              v1_q   [N];
  logic [31:0]              v1_d   [N];
  logic [31:0]              v2_q   [N];
  logic [31:0]              v2_d   [N];

  logic                     exec_valid_q, exec_valid_d;
  logic [RS_TYPE_BIT-1:0]   exec_type_q, exec_type_d;
  logic [31:0]              exec_r1_q, exec_r1_d, exec_r2_q, exec_r2_d;
  logic [ROB_WIDTH_BIT-1:0] exec_rob_q, exec_rob_d;

  logic                     iss_found, free_found;
  logic [RS_SIZE_BIT-1:0]   iss_idx, free_idx;
  logic [31:0]              in_v1, in_v2;
  logic                     in_hq1, in_hq2;

  assign full        = &busy_q;
  assign exec_valid  = exec_valid_q;
  assign exec_type   = exec_type_q;
  assign exec_r1     = exec_r1_q;
  assign exec_r2     = exec_r2_q;
  assign exec_rob_id = exec_rob_q;

  // Lowest-index ready entry and lowest-index free entry, both from registered state
  always_comb begin
    iss_found  = 1'b0;
    iss_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (busy_q[i] && !hq1_q[i] && !hq2_q[i]) begin
        iss_found = 1'b1;
        iss_idx   = i[RS_SIZE_BIT-1:0];
      end
      if (!busy_q[i]) begin
        free_found = 1'b1;
        free_idx   = i[RS_SIZE_BIT-1:0];
      end
    end
  end

  // Incoming operands can be satisfied by a broadcast in the same cycle
  always_comb begin
    in_v1  = inst_r1;
    in_hq1 = inst_has_dep1;
    in_v2  = inst_r2;
    in_hq2 = inst_has_dep2;
    if (inst_has_dep1) begin
      if (alu_ready && alu_rob_id == inst_dep1) begin
        in_v1 = alu_value;  in_hq1 = 1'b0;
      end else if (lsb_ready && lsb_rob_id == inst_dep1) begin
        in_v1 = lsb_value;  in_hq1 = 1'b0;
      end
    end
    if (inst_has_dep2) begin
      if (alu_ready && alu_rob_id == inst_dep2) begin
        in_v2 = alu_value;  in_hq2 = 1'b0;
      end else if (lsb_ready && lsb_rob_id == inst_dep2) begin
        in_v2 = lsb_value;  in_hq2 = 1'b0;
      end
    end
  end

  always_comb begin
    busy_d       = busy_q;
    hq1_d        = hq1_q;
    hq2_d        = hq2_q;
    type_d       = type_q;
    rob_d        = rob_q;
    q1_d         = q1_q;
    q2_d         = q2_q;
    v1_d         = v1_q;
    v2_d         = v2_q;
    exec_valid_d = exec_valid_q;
    exec_type_d  = exec_type_q;
    exec_r1_d    = exec_r1_q;
    exec_r2_d    = exec_r2_q;
    exec_rob_d   = exec_rob_q;
    if (rdy_in) begin
      if (clear) begin
        busy_d       = '0;
        exec_valid_d = 1'b0;
      end else begin
        for (int i = 0; i < N; i++) begin
          if (busy_q[i] && hq1_q[i]) begin
            if (alu_ready && alu_rob_id == q1_q[i]) begin
              v1_d[i] = alu_value;  hq1_d[i] = 1'b0;
            end else if (lsb_ready && lsb_rob_id == q1_q[i]) begin
              v1_d[i] = lsb_value;  hq1_d[i] = 1'b0;
            end
          end
          if (busy_q[i] && hq2_q[i]) begin
            if (alu_ready && alu_rob_id == q2_q[i]) begin
              v2_d[i] = alu_value;  hq2_d[i] = 1'b0;
            end else if (lsb_ready && lsb_rob_id == q2_q[i]) begin
              v2_d[i] = lsb_value;  hq2_d[i] = 1'b0;
            end
          end
        end
        exec_valid_d = iss_found;
        if (iss_found) begin
          busy_d[iss_idx] = 1'b0;
          exec_type_d     = type_q[iss_idx];
          exec_r1_d       = v1_q[iss_idx];
          exec_r2_d       = v2_q[iss_idx];
          exec_rob_d      = rob_q[iss_idx];
        end
        // A micro-op offered while full is silently dropped
        if (inst_valid && free_found) begin
          busy_d[free_idx] = 1'b1;
          type_d[free_idx] = inst_type;
          rob_d[free_idx]  = inst_rob_id;
          q1_d[free_idx]   = inst_dep1;
          q2_d[free_idx]   = inst_dep2;
          v1_d[free_idx]   = in_v1;
          v2_d[free_idx]   = in_v2;
          hq1_d[free_idx]  = in_hq1;
          hq2_d[free_idx]  = in_hq2;
        end
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      busy_q       <= '0;
      exec_valid_q <= 1'b0;
      exec_type_q  <= '0;
      exec_r1_q    <= '0;
      exec_r2_q    <= '0;
      exec_rob_q   <= '0;
    end else begin
      busy_q       <= busy_d;
      exec_valid_q <= exec_valid_d;
      exec_type_q  <= exec_type_d;
      exec_r1_q    <= exec_r1_d;
      exec_r2_q    <= exec_r2_d;
      exec_rob_q   <= exec_rob_d;
    end
  end

  // Payload is qualified by busy, so it needs no reset
  always_ff @(posedge clk_in) begin
    hq1_q  <= hq1_d;
    hq2_q  <= hq2_d;
    type_q <= type_d;
    rob_q  <= rob_d;
    q1_q   <= q1_d;
    q2_q   <= q2_d;
    v1_q   <= v1_d;
    v2_q   <= v2_d;
  end

endmodule
